bit_frame_receiver: RTL and testbench
=====================================

Name: bit_frame_receiver

Overview:
- Consumes the 1-bit-per-clock serial stream produced by the ROM-based data generator.
- Hunts for a fixed sync word, then deserializes the next PAY_W bits (MSB first) into a parallel word.
- Emits the word with a one-cycle valid pulse and keeps a saturating count of received frames.
- Sits directly downstream of the generator. Its outputs feed display/LED logic or a register readback.

Parameters:
- SYNC_W, 4, sync word width in bits (>=2)
- SYNC, 4'b1011, sync pattern; first-received bit is the MSB
- PAY_W, 4, payload width in bits (>=1)
- CNT_W, 8, width of frame counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  bit_in is valid this cycle; when low, all state holds
- bit_in  input  1  serial data bit
- sync_hit  output  1  one-cycle pulse: sync word just completed
- busy  output  1  high while in PAYLOAD state
- frame_data  output  PAY_W  last completed payload, MSB = first payload bit
- frame_valid  output  1  one-cycle pulse: frame_data updated this cycle
- frame_cnt  output  CNT_W  number of completed frames, saturating at all-ones

Behaviour:
- Reset is synchronous and active-high. All outputs and internal registers clear to 0; state goes to HUNT.
- Reset has priority over en. A rst cycle mid-frame discards the partial payload: no frame_valid, and frame_cnt is not incremented.
- Internal registers:
  - sr[SYNC_W-1:0]: sync shift register.
  - fill: counts 0..SYNC_W-1 and saturates; number of valid bits in sr since entering HUNT.
  - pay[PAY_W-1:0]: payload shift register.
  - bcnt: payload bit counter.
- en=0: no register changes. sync_hit and frame_valid are 0 that cycle.
- HUNT, on en=1:
  - sr <= {sr[SYNC_W-2:0], bit_in}.
  - match = ({sr[SYNC_W-2:0], bit_in} == SYNC) && (fill == SYNC_W-1). Matches are overlapping within HUNT.
  - The fill gate prevents reset-cleared zeros in sr from producing a false match.
  - On match: state <= PAYLOAD, bcnt <= 0, sync_hit <= 1 in the next cycle (registered, 1-cycle latency from the accepted bit), sr <= 0, fill <= 0.
  - Otherwise: fill increments, saturating at SYNC_W-1.
- PAYLOAD, on en=1:
  - pay <= {pay[PAY_W-2:0], bit_in}; bcnt increments.
  - No sync search in this state: payload bits equal to SYNC are not detected.
  - On the PAY_W-th accepted bit:
    - frame_data <= completed word and frame_valid <= 1, both visible the cycle after that bit.
    - frame_cnt increments unless already all-ones.
    - state <= HUNT with fill = 0. Sync search restarts fresh; no bits carry over from the payload.
- busy = (state == PAYLOAD), registered.
- The last-bit cycle and the next sync bit can be back-to-back. The bit accepted the cycle after the last payload bit is the first HUNT bit.
- frame_data holds its value until the next completed frame.
- Latency: sync_hit appears 1 cycle after the last sync bit is accepted; frame_valid appears 1 cycle after the last payload bit is accepted.
- State encoding: two states, HUNT=0 and PAYLOAD=1. Unreachable encodings return to HUNT.
- Upstream timing: the generator ROM has 1-cycle read latency. The integrator drives en low for the first cycle after rst deasserts; this block does no latency compensation.

Test Plan:
1. Continuous stream, default params: rst, en=1, bits 1,0,1,1,0,1,1,0.
   - sync_hit pulses the cycle after bit 4.
   - busy is high for the next 4 accepted bits.
   - frame_valid pulses the cycle after bit 8 with frame_data=4'b0110; frame_cnt=1.
2. en gaps: the same 8 bits with en toggling 1/0 every cycle.
   - Identical frame_data=4'b0110 and frame_cnt=1.
   - No pulses during en=0 cycles; all state holds.
3. Overlapping sync plus payload-contains-sync: bits 1,0,1,0,1,1 then 1,0,1,1.
   - Sync matches on bit 6 only; frame_data=4'b1011.
   - sync_hit pulses exactly once across the sequence.
4. False-match guard: SYNC=4'b0001; reset, then bits 1,1 then 0,0,0,1 then 4 payload bits 1,0,0,1.
   - No sync_hit on the first two bits; sync_hit after the 6th bit; frame_data=4'b1001.
5. Reset mid-payload: sync 1011, two payload bits, rst for 1 cycle, then full frame 1011 0011.
   - No frame_valid before reset; frame_cnt stays 0 through reset.
   - Then frame_data=4'b0011 and frame_cnt=1.
6. Saturation: CNT_W=2, five back-to-back frames 1011 xxxx.
   - frame_cnt sequence is 1, 2, 3, 3, 3.
   - frame_valid pulses 5 times.

Source files
------------

// File: rtl/bit_frame_receiver.sv
// Serial frame receiver: hunts for a sync word, then shifts in a PAY_W-bit payload
// MSB first and presents it with a one-cycle valid pulse and a saturating frame count.
module bit_frame_receiver #(
  parameter int unsigned              SYNC_W = 4,
  parameter logic [SYNC_W-1:0]        SYNC   = 4'b1011,
  parameter int unsigned              PAY_W  = 4,
  parameter int unsigned              CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  output logic             sync_hit,
  output logic             busy,
  output logic [PAY_W-1:0] frame_data,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned FILL_W = $clog2(SYNC_W);
  localparam int unsigned BCNT_W = (PAY_W > 1) ? $clog2(PAY_W) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(PAY_W - 1);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [SYNC_W-1:0]   sr, sr_nxt, sr_shift;
  logic [FILL_W-1:0]   fill, fill_nxt;
  logic [PAY_W-1:0]    pay, pay_nxt, pay_shift;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
  logic [PAY_W-1:0]    data_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                hit_nxt, valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      fill        <= '0;
      pay         <= '0;
      bcnt        <= '0;
      frame_data  <= '0;
      frame_cnt   <= '0;
      sync_hit    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      fill        <= fill_nxt;
      pay         <= pay_nxt;
      bcnt        <= bcnt_nxt;
      frame_data  <= data_nxt;
      frame_cnt   <= cnt_nxt;
      sync_hit    <= hit_nxt;
      frame_valid <= valid_nxt;
    end
  end

  // Shift written as a shift-or so PAY_W=1 needs no special case
  always_comb begin
    sr_shift  = {sr[SYNC_W-2:0], bit_in};
    pay_shift = (pay << 1) | PAY_W'(bit_in);
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill;
    pay_nxt   = pay;
    bcnt_nxt  = bcnt;
    data_nxt  = frame_data;
    cnt_nxt   = frame_cnt;
    hit_nxt   = 1'b0;
    valid_nxt = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          sr_nxt = sr_shift;
          // fill gate keeps reset-cleared zeros in sr from matching
          if ((sr_shift == SYNC) && (fill == FILL_LAST)) begin
            state_nxt = PAYLOAD;
            bcnt_nxt  = '0;
            hit_nxt   = 1'b1;
            sr_nxt    = '0;
            fill_nxt  = '0;
          end else if (fill != FILL_LAST) begin
            fill_nxt = fill + FILL_W'(1);
          end
        end
        PAYLOAD: begin
          pay_nxt = pay_shift;
          if (bcnt == BCNT_LAST) begin
            data_nxt  = pay_shift;
            valid_nxt = 1'b1;
            if (frame_cnt != '1) cnt_nxt = frame_cnt + CNT_W'(1);
            state_nxt = HUNT;
            fill_nxt  = '0;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt = bcnt + BCNT_W'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign busy = (state == PAYLOAD);

endmodule

// File: tb/tb_bit_frame_receiver.sv
// Directed bench for bit_frame_receiver: default, SYNC=0001 and CNT_W=2 instances share stimulus.
module tb_bit_frame_receiver;

  logic clk = 1'b0;
  logic rst, en, bit_in;

  logic       a_hit, a_busy, a_valid;
  logic [3:0] a_data;
  logic [7:0] a_cnt;
  logic       b_hit, b_busy, b_valid;
  logic [3:0] b_data;
  logic [7:0] b_cnt;
  logic       c_hit, c_busy, c_valid;
  logic [3:0] c_data;
  logic [1:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_frame_receiver u_def (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in),
    .sync_hit(a_hit), .busy(a_busy), .frame_data(a_data),
    .frame_valid(a_valid), .frame_cnt(a_cnt)
  );

  bit_frame_receiver #(.SYNC(4'b0001)) u_sync1 (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in),
    .sync_hit(b_hit), .busy(b_busy), .frame_data(b_data),
    .frame_valid(b_valid), .frame_cnt(b_cnt)
  );

  bit_frame_receiver #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in),
    .sync_hit(c_hit), .busy(c_busy), .frame_data(c_data),
    .frame_valid(c_valid), .frame_cnt(c_cnt)
  );

  task automatic step(input logic e, input logic b);
    en = e;
    bit_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if ({a_hit, a_busy, a_valid, a_data, a_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_def: got hit=%b busy=%b valid=%b data=%h cnt=%0d, want all 0",
               a_hit, a_busy, a_valid, a_data, a_cnt);
    end
    checks++;
    if ({c_hit, c_busy, c_valid, c_data, c_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_sat: got hit=%b busy=%b valid=%b data=%h cnt=%0d, want all 0",
               c_hit, c_busy, c_valid, c_data, c_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    logic [7:0] bits = 8'b1011_0110;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i]);
      checks++;
      if ({a_hit, a_busy, a_valid} !== {i == 3, (i >= 3) && (i <= 6), i == 7}) begin
        errors++;
        $display("FAIL cont_pulses bit %0d: got hit/busy/valid=%b%b%b, want %b%b%b", i + 1,
                 a_hit, a_busy, a_valid, i == 3, (i >= 3) && (i <= 6), i == 7);
      end
    end
    checks++;
    if (a_data !== 4'b0110 || a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL cont_frame: got data=%b cnt=%0d, want 0110 1", a_data, a_cnt);
    end
  endtask

  task automatic test_en_gaps();
    logic [7:0] bits = 8'b1011_0110;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i]);
      checks++;
      if ({a_hit, a_busy, a_valid} !== {i == 3, (i >= 3) && (i <= 6), i == 7}) begin
        errors++;
        $display("FAIL gap_en1 bit %0d: got hit/busy/valid=%b%b%b, want %b%b%b", i + 1,
                 a_hit, a_busy, a_valid, i == 3, (i >= 3) && (i <= 6), i == 7);
      end
      step(1'b0, ~bits[7-i]);
      checks++;
      if ({a_hit, a_busy, a_valid} !== {1'b0, (i >= 3) && (i <= 6), 1'b0}) begin
        errors++;
        $display("FAIL gap_en0 after bit %0d: got hit/busy/valid=%b%b%b, want 0%b0", i + 1,
                 a_hit, a_busy, a_valid, (i >= 3) && (i <= 6));
      end
    end
    checks++;
    if (a_data !== 4'b0110 || a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL gap_frame: got data=%b cnt=%0d, want 0110 1", a_data, a_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [9:0] bits = 10'b101011_1011;
    int hits = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, bits[9-i]);
      if (a_hit) hits++;
      checks++;
      if (a_hit !== (i == 5)) begin
        errors++;
        $display("FAIL overlap_hit bit %0d: got %b want %b", i + 1, a_hit, i == 5);
      end
    end
    checks++;
    if (hits != 1 || a_valid !== 1'b1 || a_data !== 4'b1011) begin
      errors++;
      $display("FAIL overlap_frame: got hits=%0d valid=%b data=%b, want 1 1 1011",
               hits, a_valid, a_data);
    end
  endtask

  task automatic test_false_match();
    logic [9:0] bits = 10'b11_0001_1001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, bits[9-i]);
      checks++;
      if (b_hit !== (i == 5)) begin
        errors++;
        $display("FAIL guard_hit bit %0d: got %b want %b", i + 1, b_hit, i == 5);
      end
    end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 4'b1001 || b_cnt !== 8'd1) begin
      errors++;
      $display("FAIL guard_frame: got valid=%b data=%b cnt=%0d, want 1 1001 1",
               b_valid, b_data, b_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] part = 6'b1011_00;
    logic [7:0] full = 8'b1011_0011;
    int valids = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, part[5-i]);
      if (a_valid) valids++;
    end
    checks++;
    if (valids != 0 || a_busy !== 1'b1 || a_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_pre: got valids=%0d busy=%b cnt=%0d, want 0 1 0", valids, a_busy, a_cnt);
    end
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if ({a_busy, a_valid, a_cnt, a_data} !== 14'd0) begin
      errors++;
      $display("FAIL mid_rst: got busy=%b valid=%b cnt=%0d data=%b, want all 0",
               a_busy, a_valid, a_cnt, a_data);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, full[7-i]);
    checks++;
    if (a_valid !== 1'b1 || a_data !== 4'b0011 || a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_post: got valid=%b data=%b cnt=%0d, want 1 0011 1", a_valid, a_data, a_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr;
    int valids = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fr = {4'b1011, 4'(k * 3 + 1)};
      for (int i = 0; i < 8; i++) begin
        step(1'b1, fr[7-i]);
        if (c_valid) valids++;
      end
      checks++;
      if (c_valid !== 1'b1 || c_cnt !== ((k < 2) ? 2'(k + 1) : 2'd3) || c_data !== 4'(k * 3 + 1)) begin
        errors++;
        $display("FAIL sat_frame %0d: got valid=%b cnt=%0d data=%h, want 1 %0d %h", k + 1,
                 c_valid, c_cnt, c_data, (k < 2) ? k + 1 : 3, 4'(k * 3 + 1));
      end
    end
    checks++;
    if (valids != 5) begin
      errors++;
      $display("FAIL sat_pulses: got %0d want 5", valids);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    bit_in = 1'b0;
    test_reset();
    test_continuous();
    test_en_gaps();
    test_overlap();
    test_false_match();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
